// File: rtl/traffic_pkg.sv
// traffic_pkg: scheduler states, phase indices and lamp-vector layout shared by
// traffic_phase_scheduler and rr_phase_pick.
package traffic_pkg;
    typedef enum logic [2:0] {
        ST_SELECT,
        ST_GREEN,
        ST_YELLOW,
        ST_ALL_RED,
        ST_EMG_GREEN
    } state_t;

    localparam logic [1:0] PH_NS_THRU = 2'd0;
    localparam logic [1:0] PH_NS_LEFT = 2'd1;
    localparam logic [1:0] PH_EW_THRU = 2'd2;
    localparam logic [1:0] PH_EW_LEFT = 2'd3;

    localparam int LMP_RED_NS    = 0;
    localparam int LMP_YELLOW_NS = 1;
    localparam int LMP_GREEN_NS  = 2;
    localparam int LMP_LEFT_NS   = 3;
    localparam int LMP_RED_EW    = 4;
    localparam int LMP_YELLOW_EW = 5;
    localparam int LMP_GREEN_EW  = 6;
    localparam int LMP_LEFT_EW   = 7;

    // Each direction nibble is {left, green, yellow, red}; the unserved direction is always red.
    function automatic logic [7:0] lamp_decode(input state_t st, input logic dir, input logic left);
        logic [3:0] srv;
        srv = (st == ST_GREEN || st == ST_EMG_GREEN) ? (left ? 4'b1001 : 4'b0100)
            : (st == ST_YELLOW) ? 4'b0010 : 4'b0001;
        return dir ? {srv, 4'b0001} : {4'b0001, srv};
    endfunction
endpackage

// File: rtl/rr_phase_pick.sv
// rr_phase_pick: combinational 4-way round-robin picker; searches from last+1 with
// wrap and returns phase 0 when nothing is pending.
module rr_phase_pick
    import traffic_pkg::*;
(
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic [1:0] next
);
    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest pending phase after last wins.
    always_comb begin
        next = PH_NS_THRU;
        idx  = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (pending[idx]) next = idx;
        end
    end
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: demand-driven round-robin phase scheduler for a four-way
// intersection; EMERGENCY_PREEMPT_EN enables emergency through-green preemption.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN   = 4,
    parameter int unsigned MAX_GREEN   = 12,
    parameter int unsigned LEFT_TIME   = 4,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emg_req,
    input  logic       emg_dir,
    output logic       Red_NS,
    output logic       Yellow_NS,
    output logic       Green_NS,
    output logic       freeLeft_NS,
    output logic       Red_EW,
    output logic       Yellow_EW,
    output logic       Green_EW,
    output logic       freeLeft_EW,
    output logic [1:0] phase_o,
    output logic [3:0] pending_o
);
`ifdef EMERGENCY_PREEMPT_EN
    localparam logic EMG_EN = 1'b1;
`else
    localparam logic EMG_EN = 1'b0;
`endif
    localparam int unsigned TW = CNT_W + 1;
    localparam logic [CNT_W:0] MIN_T  = TW'(MIN_GREEN);
    localparam logic [CNT_W:0] MAX_T  = TW'(MAX_GREEN);
    localparam logic [CNT_W:0] LEFT_T = TW'(LEFT_TIME);
    localparam logic [CNT_W:0] YEL_T  = TW'(YELLOW_TIME);
    localparam logic [CNT_W:0] AR_T   = TW'(ALLRED_TIME);

    state_t           state, nxt_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W:0]   t1;
    logic [1:0]       phase, nxt_phase, pick;
    logic [3:0]       pending, clr;
    logic             emg_pend, emg_active, emg_dir_q;
    logic             nxt_pend_emg, nxt_active, nxt_dir, lamp_dir, others;
    logic [7:0]       lamps, nxt_lamps;

    rr_phase_pick u_pick (
        .pending (pending),
        .last    (phase),
        .next    (pick)
    );

    assign t1     = {1'b0, timer} + TW'(1);
    assign others = |(pending & ~(4'b0001 << phase));

    always_comb begin
        nxt_state    = state;
        nxt_phase    = phase;
        nxt_active   = emg_active;
        nxt_pend_emg = emg_pend;
        nxt_dir      = emg_dir_q;
        clr          = '0;
        case (state)
            ST_SELECT: begin
                nxt_state = ST_GREEN;
                nxt_phase = pick;
                clr       = 4'b0001 << pick;
            end
            ST_GREEN:
                if (EMG_EN && emg_req) begin
                    nxt_dir = emg_dir;
                    if (phase == {emg_dir, 1'b0}) begin
                        nxt_state  = ST_EMG_GREEN;
                        nxt_active = 1'b1;
                    end else begin
                        nxt_state    = ST_YELLOW;
                        nxt_pend_emg = 1'b1;
                    end
                end else if (tick && (phase[0] ? t1 == LEFT_T
                        : others && (t1 >= MAX_T || (t1 >= MIN_T && !req[phase]))))
                    nxt_state = ST_YELLOW;
            ST_YELLOW:
                if (tick && t1 >= YEL_T) nxt_state = ST_ALL_RED;
            ST_ALL_RED:
                if (tick && t1 >= AR_T) begin
                    nxt_state    = emg_pend ? ST_EMG_GREEN : ST_SELECT;
                    nxt_active   = emg_pend;
                    nxt_pend_emg = 1'b0;
                end
            ST_EMG_GREEN:
                if (!emg_req) nxt_state = ST_YELLOW;
            default: nxt_state = ST_ALL_RED;
        endcase
        // Emergency green and its yellow follow the emergency direction, not the rr pointer.
        lamp_dir  = (nxt_state == ST_EMG_GREEN || (nxt_state == ST_YELLOW && nxt_active))
                  ? nxt_dir : nxt_phase[1];
        nxt_lamps = lamp_decode(nxt_state, lamp_dir, nxt_phase[0] && nxt_state == ST_GREEN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_ALL_RED;
            timer      <= '0;
            phase      <= PH_EW_LEFT;
            pending    <= '0;
            emg_pend   <= 1'b0;
            emg_active <= 1'b0;
            emg_dir_q  <= 1'b0;
            lamps      <= 8'h11;
        end else begin
            state      <= nxt_state;
            timer      <= (nxt_state != state) ? '0
                        : (tick && timer != '1) ? t1[CNT_W-1:0] : timer;
            phase      <= nxt_phase;
            pending    <= (pending | req) & ~clr;
            emg_pend   <= nxt_pend_emg;
            emg_active <= nxt_active;
            emg_dir_q  <= nxt_dir;
            lamps      <= nxt_lamps;
        end
    end

    assign Red_NS      = lamps[LMP_RED_NS];
    assign Yellow_NS   = lamps[LMP_YELLOW_NS];
    assign Green_NS    = lamps[LMP_GREEN_NS];
    assign freeLeft_NS = lamps[LMP_LEFT_NS];
    assign Red_EW      = lamps[LMP_RED_EW];
    assign Yellow_EW   = lamps[LMP_YELLOW_EW];
    assign Green_EW    = lamps[LMP_GREEN_EW];
    assign freeLeft_EW = lamps[LMP_LEFT_EW];
    assign phase_o     = phase;
    assign pending_o   = pending;
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: scripted scenarios push per-cycle lamp/phase/pending
// expectations into a scoreboard that is drained and compared at each falling edge.
module tb_traffic_phase_scheduler;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       emg_req = 1'b0;
    logic       emg_dir = 1'b0;
    logic       Red_NS, Yellow_NS, Green_NS, freeLeft_NS;
    logic       Red_EW, Yellow_EW, Green_EW, freeLeft_EW;
    logic [1:0] phase_o;
    logic [3:0] pending_o;
    logic [7:0] lamps;

    localparam logic [7:0] RR  = 8'b1000_1000;
    localparam logic [7:0] NSG = 8'b0010_1000;
    localparam logic [7:0] NSY = 8'b0100_1000;
    localparam logic [7:0] NSL = 8'b1001_1000;
    localparam logic [7:0] EWG = 8'b1000_0010;
    localparam logic [7:0] EWY = 8'b1000_0100;
    localparam logic [7:0] EWL = 8'b1000_1001;

    typedef struct {
        int         due;
        string      tag;
        logic [7:0] lamps;
        logic [1:0] ph;
        int         pend;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic found;

    traffic_phase_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .req         (req),
        .emg_req     (emg_req),
        .emg_dir     (emg_dir),
        .Red_NS      (Red_NS),
        .Yellow_NS   (Yellow_NS),
        .Green_NS    (Green_NS),
        .freeLeft_NS (freeLeft_NS),
        .Red_EW      (Red_EW),
        .Yellow_EW   (Yellow_EW),
        .Green_EW    (Green_EW),
        .freeLeft_EW (freeLeft_EW),
        .phase_o     (phase_o),
        .pending_o   (pending_o)
    );

    assign lamps = {Red_NS, Yellow_NS, Green_NS, freeLeft_NS, Red_EW, Yellow_EW, Green_EW, freeLeft_EW};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk)
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            check({cur.tag, ".lamps"}, 32'(lamps), 32'(cur.lamps));
            check({cur.tag, ".phase"}, 32'(phase_o), 32'(cur.ph));
            if (cur.pend >= 0) check({cur.tag, ".pending"}, 32'(pending_o), 32'(cur.pend));
        end

    task automatic run(input int n, input logic t, input logic [3:0] r, input logic e,
                       input logic [7:0] l, input logic [1:0] p, input int pd, input string tag);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick    = t;
            req     = r;
            emg_req = e;
            x.due   = cyc + 1;
            x.tag   = $sformatf("%s[%0d]", tag, i);
            x.lamps = l;
            x.ph    = p;
            x.pend  = pd;
            sb.push_back(x);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.lamps", 32'(lamps), 32'(RR));
        check("rst.phase", 32'(phase_o), 32'd3);
        check("rst.pending", 32'(pending_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // Startup: all-red holds without tick, then one tick of all-red, then NS rest.
        run(1, 1'b0, 4'b0000, 1'b0, RR, 2'd3, 0, "no_tick");
        run(1, 1'b1, 4'b0000, 1'b0, RR, 2'd3, -1, "first_allred");
        // EW left request: NS green ends after MIN_GREEN ticks, left runs LEFT_TIME ticks.
        run(1, 1'b1, 4'b1000, 1'b0, NSG, 2'd0, 4'b1000, "ns_green0");
        run(3, 1'b1, 4'b0000, 1'b0, NSG, 2'd0, -1, "ns_min");
        run(3, 1'b1, 4'b0000, 1'b0, NSY, 2'd0, -1, "ns_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd0, -1, "ar_sel");
        run(1, 1'b1, 4'b0000, 1'b0, EWL, 2'd3, 0, "ewl0");
        run(3, 1'b1, 4'b0000, 1'b0, EWL, 2'd3, -1, "ewl");
        run(3, 1'b1, 4'b0000, 1'b0, EWY, 2'd3, -1, "ewl_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd3, -1, "ar_sel");
        // NS demand held: green capped at MAX_GREEN when EW thru waits.
        run(1, 1'b1, 4'b0101, 1'b0, NSG, 2'd0, 4'b0100, "max0");
        run(11, 1'b1, 4'b0001, 1'b0, NSG, 2'd0, 4'b0101, "max");
        run(3, 1'b1, 4'b0001, 1'b0, NSY, 2'd0, -1, "max_yel");
        run(2, 1'b1, 4'b0001, 1'b0, RR, 2'd0, -1, "ar_sel");
        run(1, 1'b1, 4'b0000, 1'b0, EWG, 2'd2, 4'b0001, "ewg0");
        run(3, 1'b1, 4'b0000, 1'b0, EWG, 2'd2, -1, "ewg");
        run(3, 1'b1, 4'b0000, 1'b0, EWY, 2'd2, -1, "ewg_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd2, -1, "ar_sel");
        // Wrap 3->0 picks NS thru; then 1110 served in order 1, 2, 3, then idle to 0.
        run(1, 1'b1, 4'b1110, 1'b0, NSG, 2'd0, 4'b1110, "wrap0");
        run(3, 1'b1, 4'b0000, 1'b0, NSG, 2'd0, -1, "rr_ns");
        run(3, 1'b1, 4'b0000, 1'b0, NSY, 2'd0, -1, "rr_nsy");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd0, -1, "ar_sel");
        run(1, 1'b1, 4'b0000, 1'b0, NSL, 2'd1, 4'b1100, "rr1_0");
        run(3, 1'b1, 4'b0000, 1'b0, NSL, 2'd1, -1, "rr1");
        run(3, 1'b1, 4'b0000, 1'b0, NSY, 2'd1, -1, "rr1_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd1, -1, "ar_sel");
        run(4, 1'b1, 4'b0000, 1'b0, EWG, 2'd2, 4'b1000, "rr2");
        run(3, 1'b1, 4'b0000, 1'b0, EWY, 2'd2, -1, "rr2_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd2, -1, "ar_sel");
        run(4, 1'b1, 4'b0000, 1'b0, EWL, 2'd3, 0, "rr3");
        run(3, 1'b1, 4'b0000, 1'b0, EWY, 2'd3, -1, "rr3_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd3, -1, "ar_sel");
        run(1, 1'b1, 4'b0100, 1'b0, NSG, 2'd0, -1, "idle0");
        run(3, 1'b1, 4'b0000, 1'b0, NSG, 2'd0, -1, "ns");
        run(3, 1'b1, 4'b0000, 1'b0, NSY, 2'd0, -1, "nsy");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd0, -1, "ar_sel");
        run(2, 1'b1, 4'b0000, 1'b0, EWG, 2'd2, -1, "ew_tick1");
`ifdef EMERGENCY_PREEMPT_EN
        run(3, 1'b1, 4'b0000, 1'b1, EWY, 2'd2, -1, "emg_yel");
        run(1, 1'b1, 4'b0000, 1'b1, RR, 2'd2, -1, "emg_ar");
        run(4, 1'b1, 4'b0000, 1'b1, NSG, 2'd2, -1, "emg_green");
        run(3, 1'b1, 4'b0000, 1'b0, NSY, 2'd2, -1, "emg_end_yel");
        run(2, 1'b1, 4'b0000, 1'b0, RR, 2'd2, -1, "emg_end_ar");
        run(1, 1'b1, 4'b0000, 1'b0, NSG, 2'd0, 0, "emg_resume");
        run(1, 1'b1, 4'b0010, 1'b0, NSG, 2'd0, -1, "pre_rst");
`else
        run(8, 1'b1, 4'b0000, 1'b1, EWG, 2'd2, -1, "emg_ignored");
        run(6, 1'b1, 4'b0000, 1'b0, EWG, 2'd2, 0, "ew_rest");
        run(1, 1'b1, 4'b0010, 1'b0, EWG, 2'd2, -1, "pre_rst");
`endif
        repeat (3) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        // Reset asserted mid-yellow must clear lamps and pending without a clock edge.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            found = Yellow_NS | Yellow_EW;
        end
        check("yellow_reached", 32'(found), 32'd1);
        check("pend_pre_rst", 32'(pending_o), 32'b0010);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst.lamps", 32'(lamps), 32'(RR));
        check("async_rst.phase", 32'(phase_o), 32'd3);
        check("async_rst.pending", 32'(pending_o), 32'd0);
        @(negedge clk);
        check("hold_rst.lamps", 32'(lamps), 32'(RR));
        reset_n = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
